// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : frame geometry, timeout default and FSM state encoding   |
// | shared by the UART frame receive and transmit controllers.          |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int FRAME_BYTES    = 40;
    localparam int FRAME_BITS     = FRAME_BYTES * 8;
    localparam int TIMEOUT_CYCLES = 50000;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RECV = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_frame_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_frame_rx_if : byte strobe in, assembled frame and status out.  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
interface uart_frame_rx_if #(
    parameter int FRAME_BYTES = uart_pkg::FRAME_BYTES
);
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);

    logic                     uart_read_done;
    logic [7:0]               read_data;
    logic                     recv_en;
    logic [FRAME_BYTES*8-1:0] data;
    logic                     recv_done;
    logic                     busy;
    logic                     timeout_err;
    logic [CNT_W-1:0]         byte_cnt;

    modport master (
        output uart_read_done, read_data, recv_en,
        input  data, recv_done, busy, timeout_err, byte_cnt
    );

    modport slave (
        input  uart_read_done, read_data, recv_en,
        output data, recv_done, busy, timeout_err, byte_cnt
    );

endinterface
`default_nettype wire

// File: rtl/uart_gap_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_gap_timer : counts idle cycles between received bytes.         |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic run,
    output logic      expired
);
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] c_GAP_MAX  = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] c_GAP_FIRE = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;

    always_comb begin
        gap_d = gap_q;
        if (clear) begin
            gap_d = '0;
        end else if (run && (gap_q != c_GAP_MAX)) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    // A clear (byte strobe) in the firing cycle suppresses expiry.
    assign expired = run && !clear && (gap_q == c_GAP_FIRE);

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_frame_rx : assembles FRAME_BYTES received bytes into a frame,  |
// | publishing it atomically and dropping stalled partial frames.       |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_frame_rx #(
    parameter int FRAME_BYTES    = uart_pkg::FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
) (
    input  wire logic      clk,
    input  wire logic      rst,
    uart_frame_rx_if.slave bus
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    state_t state_q;
    state_t state_d;

    logic [FRAME_BYTES-1:0][7:0] shadow_q;
    logic [FRAME_BYTES-1:0][7:0] shadow_d;
    logic [FRAME_BYTES*8-1:0]    data_q;
    logic [FRAME_BYTES*8-1:0]    data_d;
    logic [CNT_W-1:0]            byte_cnt_q;
    logic [CNT_W-1:0]            byte_cnt_d;
    logic                        recv_done_q;
    logic                        recv_done_d;
    logic                        timeout_err_q;
    logic                        timeout_err_d;

    logic w_strobe;
    logic w_start;
    logic w_gap_clear;
    logic w_gap_run;
    logic w_gap_expired;

    assign w_strobe    = bus.uart_read_done;
    assign w_start     = bus.uart_read_done && bus.recv_en;
    assign w_gap_run   = (state_q == c_ST_RECV);
    assign w_gap_clear = w_strobe || (state_q != c_ST_RECV);

    uart_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_gap_clear),
        .run     (w_gap_run),
        .expired (w_gap_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_start) begin
                    state_d = c_ST_RECV;
                end
            end
            c_ST_RECV: begin
                if (w_strobe) begin
                    if (byte_cnt_q == c_LAST_IDX) begin
                        state_d = c_ST_DONE;
                    end
                end else if (w_gap_expired) begin
                    state_d = c_ST_IDLE;
                end
            end
            c_ST_DONE: begin
                state_d = w_start ? c_ST_RECV : c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // recv_en only gates frame start; mid-frame strobes are always taken.
    always_comb begin
        shadow_d      = shadow_q;
        data_d        = data_q;
        byte_cnt_d    = byte_cnt_q;
        recv_done_d   = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (w_start) begin
                    shadow_d[0] = bus.read_data;
                    byte_cnt_d  = c_ONE;
                end
            end
            c_ST_RECV: begin
                if (w_strobe) begin
                    shadow_d[byte_cnt_q[IDX_W-1:0]] = bus.read_data;
                    byte_cnt_d                      = byte_cnt_q + c_ONE;
                end else if (w_gap_expired) begin
                    timeout_err_d = 1'b1;
                    byte_cnt_d    = '0;
                end
            end
            c_ST_DONE: begin
                data_d      = shadow_q;
                recv_done_d = 1'b1;
                if (w_start) begin
                    shadow_d[0] = bus.read_data;
                    byte_cnt_d  = c_ONE;
                end else begin
                    byte_cnt_d  = '0;
                end
            end
            default: begin
                byte_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q      <= '0;
            data_q        <= '0;
            byte_cnt_q    <= '0;
            recv_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            data_q        <= data_d;
            byte_cnt_q    <= byte_cnt_d;
            recv_done_q   <= recv_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.recv_done   = recv_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.byte_cnt    = byte_cnt_q;
    assign bus.busy        = (state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_frame_rx : directed self-checking bench for uart_frame_rx.  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_uart_frame_rx;
    localparam int FB = 40;
    localparam int T  = 64;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [FB*8-1:0] exp_inc;
    logic [FB*8-1:0] exp_a;
    logic [FB*8-1:0] exp_b;
    logic [FB*8-1:0] exp_c;
    logic [FB*8-1:0] exp_d;

    uart_frame_rx_if #(.FRAME_BYTES(FB)) bus ();

    uart_frame_rx #(
        .FRAME_BYTES    (FB),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe is high for exactly the cycle that ends at the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        bus.uart_read_done = 1'b1;
        bus.read_data      = b;
        @(posedge clk);
        #1;
        bus.uart_read_done = 1'b0;
        bus.read_data      = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (bus.data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.data); end
        checks++; if (bus.recv_done !== 1'b0) begin errors++; $display("FAIL reset_recv_done: got %b want 0", bus.recv_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
        checks++; if (bus.byte_cnt !== 6'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d want 0", bus.byte_cnt); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_full_frame();
        for (int k = 0; k < FB; k++) begin
            send_byte(8'(k + 1));
            if (k == 0) begin
                checks++; if (bus.byte_cnt !== 6'd1) begin errors++; $display("FAIL full_first_cnt: got %0d want 1", bus.byte_cnt); end
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL full_first_busy: got %b want 1", bus.busy); end
            end
            if (k == FB - 1) break;
            idle(2);
        end
        checks++; if (bus.recv_done !== 1'b0) begin errors++; $display("FAIL full_done_early: got %b want 0", bus.recv_done); end
        checks++; if (bus.byte_cnt !== 6'd40) begin errors++; $display("FAIL full_cnt_40: got %0d want 40", bus.byte_cnt); end
        checks++; if (bus.data !== '0) begin errors++; $display("FAIL full_data_early: got %0h want 0", bus.data); end
        idle(1);
        checks++; if (bus.recv_done !== 1'b1) begin errors++; $display("FAIL full_done_n2: got %b want 1", bus.recv_done); end
        checks++; if (bus.data[7:0] !== 8'h01) begin errors++; $display("FAIL full_byte0: got %0h want 01", bus.data[7:0]); end
        checks++; if (bus.data[319:312] !== 8'h28) begin errors++; $display("FAIL full_byte39: got %0h want 28", bus.data[319:312]); end
        checks++; if (bus.data !== exp_inc) begin errors++; $display("FAIL full_data: got %0h want %0h", bus.data, exp_inc); end
        checks++; if (bus.byte_cnt !== 6'd0) begin errors++; $display("FAIL full_cnt_clr: got %0d want 0", bus.byte_cnt); end
        idle(1);
        checks++; if (bus.recv_done !== 1'b0) begin errors++; $display("FAIL full_done_width: got %b want 0", bus.recv_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        int pulses;
        int first;
        pulses = 0;
        first  = -1;
        for (int k = 0; k < 10; k++) send_byte(8'hC0 + 8'(k));
        for (int i = 1; i <= T + 4; i++) begin
            if (i == T) begin
                checks++; if (bus.byte_cnt !== 6'd10) begin errors++; $display("FAIL to_cnt_before: got %0d want 10", bus.byte_cnt); end
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL to_busy_before: got %b want 1", bus.busy); end
            end
            if (bus.timeout_err === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            idle(1);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", pulses); end
        checks++; if (first !== T + 1) begin errors++; $display("FAIL to_cycle: got %0d want %0d", first, T + 1); end
        checks++; if (bus.byte_cnt !== 6'd0) begin errors++; $display("FAIL to_cnt_after: got %0d want 0", bus.byte_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", bus.busy); end
        checks++; if (bus.data !== exp_inc) begin errors++; $display("FAIL to_data_kept: got %0h want %0h", bus.data, exp_inc); end
    endtask

    task automatic test_done_strobe();
        for (int k = 0; k < FB; k++) send_byte(8'h50 + 8'(k));
        send_byte(8'hAA);
        checks++; if (bus.recv_done !== 1'b1) begin errors++; $display("FAIL ds_done: got %b want 1", bus.recv_done); end
        checks++; if (bus.data !== exp_a) begin errors++; $display("FAIL ds_data1: got %0h want %0h", bus.data, exp_a); end
        checks++; if (bus.byte_cnt !== 6'd1) begin errors++; $display("FAIL ds_cnt: got %0d want 1", bus.byte_cnt); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ds_busy: got %b want 1", bus.busy); end
        for (int k = 1; k < FB; k++) send_byte(8'(k));
        idle(1);
        checks++; if (bus.recv_done !== 1'b1) begin errors++; $display("FAIL ds_done2: got %b want 1", bus.recv_done); end
        checks++; if (bus.data[7:0] !== 8'hAA) begin errors++; $display("FAIL ds_slot0: got %0h want aa", bus.data[7:0]); end
        checks++; if (bus.data !== exp_b) begin errors++; $display("FAIL ds_data2: got %0h want %0h", bus.data, exp_b); end
        idle(2);
    endtask

    task automatic test_timeout_race();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 3; k++) send_byte(8'h11 * 8'(k + 1));
        idle(T - 1);
        send_byte(8'h44);
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL race_no_to: got %b want 0", bus.timeout_err); end
        checks++; if (bus.byte_cnt !== 6'd4) begin errors++; $display("FAIL race_cnt: got %0d want 4", bus.byte_cnt); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL race_busy: got %b want 1", bus.busy); end
        for (int i = 1; i <= T + 4; i++) begin
            if (bus.timeout_err === 1'b1) pulses++;
            idle(1);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL race_later_to: got %0d want 1", pulses); end
        checks++; if (bus.data !== exp_b) begin errors++; $display("FAIL race_data_kept: got %0h want %0h", bus.data, exp_b); end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 20; k++) send_byte(8'h90 + 8'(k));
        checks++; if (bus.data !== exp_b) begin errors++; $display("FAIL rm_partial_hidden: got %0h want %0h", bus.data, exp_b); end
        rst                = 1'b1;
        bus.uart_read_done = 1'b1;
        bus.read_data      = 8'h5A;
        idle(1);
        rst                = 1'b0;
        bus.uart_read_done = 1'b0;
        checks++; if (bus.byte_cnt !== 6'd0) begin errors++; $display("FAIL rm_cnt: got %0d want 0", bus.byte_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
        checks++; if (bus.data !== '0) begin errors++; $display("FAIL rm_data: got %0h want 0", bus.data); end
        checks++; if ((bus.recv_done | bus.timeout_err) !== 1'b0) begin errors++; $display("FAIL rm_pulses: got %b%b want 00", bus.recv_done, bus.timeout_err); end
        for (int k = 0; k < FB; k++) send_byte(8'hFF - 8'(k));
        idle(1);
        checks++; if (bus.recv_done !== 1'b1) begin errors++; $display("FAIL rm_done: got %b want 1", bus.recv_done); end
        checks++; if (bus.data !== exp_c) begin errors++; $display("FAIL rm_frame: got %0h want %0h", bus.data, exp_c); end
        idle(2);
    endtask

    task automatic test_recv_en();
        bus.recv_en = 1'b0;
        for (int k = 0; k < 3; k++) send_byte(8'h77);
        checks++; if (bus.byte_cnt !== 6'd0) begin errors++; $display("FAIL en_gated_cnt: got %0d want 0", bus.byte_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_gated_busy: got %b want 0", bus.busy); end
        bus.recv_en = 1'b1;
        for (int k = 0; k < FB; k++) begin
            send_byte(8'h30 + 8'(k));
            if (k == 4) bus.recv_en = 1'b0;
        end
        checks++; if (bus.byte_cnt !== 6'd40) begin errors++; $display("FAIL en_mid_cnt: got %0d want 40", bus.byte_cnt); end
        idle(1);
        checks++; if (bus.recv_done !== 1'b1) begin errors++; $display("FAIL en_mid_done: got %b want 1", bus.recv_done); end
        checks++; if (bus.data !== exp_d) begin errors++; $display("FAIL en_mid_data: got %0h want %0h", bus.data, exp_d); end
        send_byte(8'h66);
        checks++; if (bus.byte_cnt !== 6'd0) begin errors++; $display("FAIL en_after_cnt: got %0d want 0", bus.byte_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_after_busy: got %b want 0", bus.busy); end
    endtask

    initial begin
        for (int k = 0; k < FB; k++) begin
            exp_inc[8*k +: 8] = 8'(k + 1);
            exp_a[8*k +: 8]   = 8'h50 + 8'(k);
            exp_b[8*k +: 8]   = (k == 0) ? 8'hAA : 8'(k);
            exp_c[8*k +: 8]   = 8'hFF - 8'(k);
            exp_d[8*k +: 8]   = 8'h30 + 8'(k);
        end
        rst                = 1'b1;
        bus.uart_read_done = 1'b0;
        bus.read_data      = 8'h00;
        bus.recv_en        = 1'b1;
        test_reset();
        test_full_frame();
        test_timeout();
        test_done_strobe();
        test_timeout_race();
        test_reset_midframe();
        test_recv_en();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
